// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, FSM state encoding and x0 index for the MEM stage.
package mem_access_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int RD_W_DEF = 5;
   localparam int X0_IDX = 0;
   typedef enum logic {ST_IDLE, ST_REQ} state_e;
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: data-memory request/response bus between the MEM stage (master) and memory (slave).
interface mem_access_if #(parameter int DATA_W = 32);
   logic req;
   logic we;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic ready;
   logic [DATA_W-1:0] rdata;
   modport master(output req, we, addr, wdata, input ready, rdata);
   modport slave(input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB output register; a bubble clears valid and reg_en but holds data/rd.
module mem_wb_reg #(parameter int DATA_W = 32, parameter int RD_W = 5) (
   input  logic              clock,
   input  logic              reset,
   input  logic              bubble,
   input  logic [DATA_W-1:0] wb_data_d,
   input  logic [RD_W-1:0]   wb_rd_d,
   input  logic              wb_reg_en_d,
   output logic [DATA_W-1:0] wb_data,
   output logic [RD_W-1:0]   wb_rd,
   output logic              wb_reg_en,
   output logic              wb_valid
);
   logic [DATA_W-1:0] wb_data_q;
   logic [RD_W-1:0] wb_rd_q;
   logic wb_reg_en_q, wb_valid_q;
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_data_q <= '0;
         wb_rd_q <= '0;
         wb_reg_en_q <= 1'b0;
         wb_valid_q <= 1'b0;
      end else if (bubble) begin
         wb_reg_en_q <= 1'b0;
         wb_valid_q <= 1'b0;
      end else begin
         wb_data_q <= wb_data_d;
         wb_rd_q <= wb_rd_d;
         wb_reg_en_q <= wb_reg_en_d;
         wb_valid_q <= 1'b1;
      end
   end
   assign wb_data = wb_data_q;
   assign wb_rd = wb_rd_q;
   assign wb_reg_en = wb_reg_en_q;
   assign wb_valid = wb_valid_q;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: RISC-V MEM stage issuing load/store over a req/ready bus and stalling until it completes.
// Define MEM_MISALIGN_CHECK_EN to reject misaligned memory ops with a misalign_err pulse instead of issuing them.
module mem_access_unit import mem_access_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_W = RD_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] store_data_in,
   input  logic [RD_W-1:0]   rd_in,
   input  logic              memtoreg_in,
   input  logic              we_in,
   input  logic              reg_en_in,
   output logic              stall,
   mem_access_if.master      dmem,
   output logic [DATA_W-1:0] wb_data,
   output logic [RD_W-1:0]   wb_rd,
   output logic              wb_reg_en,
   output logic              wb_valid,
   output logic              misalign_err
);
   state_e state_q, state_d;
   logic [DATA_W-1:0] req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
   logic [RD_W-1:0] req_rd_q, req_rd_d;
   logic req_we_q, req_we_d, req_memtoreg_q, req_memtoreg_d, req_reg_en_q, req_reg_en_d;
   logic misalign_q, misalign_d;
   logic mem_op, mis, in_req, capture, is_load, bubble, wb_reg_en_d;
   logic [DATA_W-1:0] wb_data_d;
   logic [RD_W-1:0] wb_rd_d;
`ifdef MEM_MISALIGN_CHECK_EN
   assign mis = (memtoreg_in | we_in) && (alu_result_in[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif
   always_comb begin
      mem_op = memtoreg_in | we_in;
      in_req = state_q == ST_REQ;
      capture = !in_req && mem_op && !mis;
      stall = !reset && (in_req ? !dmem.ready : capture);
      bubble = in_req ? !dmem.ready : capture;
      state_d = in_req ? (dmem.ready ? ST_IDLE : ST_REQ) : (capture ? ST_REQ : ST_IDLE);
      req_addr_d = capture ? alu_result_in : req_addr_q;
      req_wdata_d = capture ? store_data_in : req_wdata_q;
      req_rd_d = capture ? rd_in : req_rd_q;
      req_we_d = capture ? we_in : req_we_q;
      req_memtoreg_d = capture ? memtoreg_in : req_memtoreg_q;
      req_reg_en_d = capture ? reg_en_in : req_reg_en_q;
      // store wins when both memtoreg and we are set
      is_load = req_memtoreg_q && !req_we_q;
      wb_data_d = in_req ? (is_load ? dmem.rdata : req_addr_q) : alu_result_in;
      wb_rd_d = in_req ? req_rd_q : rd_in;
      wb_reg_en_d = in_req ? is_load && req_reg_en_q && (req_rd_q != RD_W'(X0_IDX))
                           : !mis && reg_en_in && (rd_in != RD_W'(X0_IDX));
      misalign_d = !in_req && mis;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         req_addr_q <= '0;
         req_wdata_q <= '0;
         req_rd_q <= '0;
         req_we_q <= 1'b0;
         req_memtoreg_q <= 1'b0;
         req_reg_en_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_addr_q <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_rd_q <= req_rd_d;
         req_we_q <= req_we_d;
         req_memtoreg_q <= req_memtoreg_d;
         req_reg_en_q <= req_reg_en_d;
         misalign_q <= misalign_d;
      end
   end
   assign dmem.req = state_q == ST_REQ;
   assign dmem.we = req_we_q;
   assign dmem.addr = {req_addr_q[DATA_W-1:2], 2'b00};
   assign dmem.wdata = req_wdata_q;
   assign misalign_err = misalign_q;
   mem_wb_reg #(.DATA_W(DATA_W), .RD_W(RD_W)) u_wb (
      .clock(clock), .reset(reset), .bubble(bubble),
      .wb_data_d(wb_data_d), .wb_rd_d(wb_rd_d), .wb_reg_en_d(wb_reg_en_d),
      .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_en(wb_reg_en), .wb_valid(wb_valid)
   );
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random MEM-stage ops against a per-instruction reference model.
// Honours MEM_MISALIGN_CHECK_EN the same way the design does.
module tb_mem_access_unit;
`ifdef MEM_MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif
   logic clock = 1'b0;
   logic reset;
   logic [31:0] alu_result_in, store_data_in, wb_data;
   logic [4:0] rd_in, wb_rd;
   logic memtoreg_in, we_in, reg_en_in, stall, wb_reg_en, wb_valid, misalign_err;
   always #5 clock = ~clock;
   mem_access_if #(.DATA_W(32)) dmem();
   mem_access_unit #(.DATA_W(32), .RD_W(5)) dut (
      .clock(clock), .reset(reset), .alu_result_in(alu_result_in), .store_data_in(store_data_in),
      .rd_in(rd_in), .memtoreg_in(memtoreg_in), .we_in(we_in), .reg_en_in(reg_en_in),
      .stall(stall), .dmem(dmem), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_en(wb_reg_en),
      .wb_valid(wb_valid), .misalign_err(misalign_err)
   );
   int total = 0, bad = 0;
   logic [31:0] mem [256];
   logic pv, pen, pmis, pcd, pcrd;
   logic [31:0] pdata;
   logic [4:0] prd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_wb();
      check("wb_valid", 32'(wb_valid), 32'(pv));
      check("misalign_err", 32'(misalign_err), 32'(pmis));
      if (pv) begin
         check("wb_reg_en", 32'(wb_reg_en), 32'(pen));
         if (pcrd) check("wb_rd", 32'(wb_rd), 32'(prd));
         if (pcd) check("wb_data", wb_data, pdata);
      end
   endtask

   task automatic expect_nop();
      pv = 1'b1; pen = 1'b0; pmis = 1'b0; pcd = 1'b1; pcrd = 1'b1; pdata = 32'h0; prd = 5'd0;
   endtask

   // Present one instruction (at posedge+1) and hold it until the model says it is consumed.
   task automatic run_op(input logic mt, input logic we, input logic re, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] rd, input int waits);
      logic mem_op, mis, rdy, done;
      int age;
      memtoreg_in = mt; we_in = we; reg_en_in = re; alu_result_in = alu; store_data_in = sd; rd_in = rd;
      mem_op = mt | we;
      mis = MIS_EN && mem_op && (alu[1:0] != 2'b00);
      age = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clock);
         check_wb();
         rdy = mem_op && !mis && (age > waits);
         dmem.ready = rdy;
         dmem.rdata = rdy ? mem[alu[9:2]] : $urandom;
         #1;
         check("stall", 32'(stall), 32'(mem_op && !mis && !rdy));
         check("dmem_req", 32'(dmem.req), 32'(mem_op && !mis && age > 0));
         if (mem_op && !mis && age > 0) begin
            check("dmem_addr", dmem.addr, {alu[31:2], 2'b00});
            check("dmem_we", 32'(dmem.we), 32'(we));
            if (we) check("dmem_wdata", dmem.wdata, sd);
         end
         done = !(mem_op && !mis && !rdy);
         pv = done;
         pmis = done && mis;
         pen = done && !mis && !we && re && (rd != 5'd0);
         pcd = done && !mis && !we;
         pcrd = done && !we;
         pdata = (mt && !we) ? mem[alu[9:2]] : alu;
         prd = rd;
         if (done && we && !mis) mem[alu[9:2]] = sd;
         @(posedge clock);
         #1;
         dmem.ready = 1'b0;
         age++;
      end
   endtask

   initial begin
      logic [31:0] a;
      int k;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[64] = 32'hDEADBEEF;
      reset = 1'b1;
      memtoreg_in = 1'b0; we_in = 1'b0; reg_en_in = 1'b0;
      alu_result_in = '0; store_data_in = '0; rd_in = '0;
      dmem.ready = 1'b0; dmem.rdata = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      pv = 1'b0; pmis = 1'b0;
      check_wb();
      check("rst_wb_data", wb_data, 32'h0);
      check("rst_wb_rd", 32'(wb_rd), 32'h0);
      check("rst_wb_reg_en", 32'(wb_reg_en), 32'h0);
      check("rst_dmem_req", 32'(dmem.req), 32'h0);
      @(posedge clock);
      #1 expect_nop();
      run_op(1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd5, 0);
      run_op(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd9, 3);
      run_op(1'b0, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 5'd4, 0);
      run_op(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd0, 1);
      run_op(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd6, 2);
      run_op(1'b0, 1'b0, 1'b1, 32'hCAFE0001, 32'h0, 5'd7, 0);
      run_op(1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 5'd8, 0);
      run_op(1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 5'd2, 0);
      // reset while waiting in REQ drops the response
      memtoreg_in = 1'b1; we_in = 1'b0; reg_en_in = 1'b1; alu_result_in = 32'h200; rd_in = 5'd3;
      @(negedge clock);
      check_wb();
      #1 check("pre_rst_stall", 32'(stall), 32'h1);
      @(posedge clock);
      @(negedge clock);
      check("pre_rst_req", 32'(dmem.req), 32'h1);
      reset = 1'b1;
      #1 check("stall_in_reset", 32'(stall), 32'h0);
      @(posedge clock);
      #1 reset = 1'b0;
      memtoreg_in = 1'b0; reg_en_in = 1'b0; rd_in = 5'd0; alu_result_in = 32'h0;
      @(negedge clock);
      pv = 1'b0; pmis = 1'b0;
      check_wb();
      check("post_rst_req", 32'(dmem.req), 32'h0);
      check("post_rst_stall", 32'(stall), 32'h0);
      check("post_rst_reg_en", 32'(wb_reg_en), 32'h0);
      @(posedge clock);
      #1 expect_nop();
      for (int n = 0; n < 400; n++) begin
         k = $urandom_range(0, 4);
         a = (k < 2) ? $urandom : 32'($urandom_range(0, 1023));
         if (k >= 2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         run_op(k == 2 || k == 4, k >= 3, 1'($urandom), a, $urandom, 5'($urandom), $urandom_range(0, 3));
      end
      @(negedge clock);
      check_wb();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
